// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: entry and result bundles.
// Exports BRQ_ADDR_W, word_t, brq_entry_t, brq_result_t, next_seq_pc().
package branch_queue_pkg;

  localparam int BRQ_ADDR_W = 32;

  typedef logic [BRQ_ADDR_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    logic  taken;
    word_t target;
    logic  is_jalr;
  } brq_entry_t;

  typedef struct packed {
    logic  mispredict;
    word_t redirect_pc;
  } brq_result_t;

  // Fall-through PC; wraps modulo the address width.
  function automatic word_t next_seq_pc(word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor bus of the branch resolve queue.
// master: fetch+execute side; slave: the queue itself.
interface branch_resolve_queue_if #(
  parameter int ADDR_W = 32
);

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_pc;
  logic              enq_taken;
  logic [ADDR_W-1:0] enq_target;
  logic              enq_is_jalr;

  logic              res_valid;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              flush;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_is_jalr;

  modport master (
    output enq_valid, enq_pc, enq_taken,
    output enq_target, enq_is_jalr,
    output res_valid, res_taken, res_target,
    output flush,
    input  enq_ready, mispredict, redirect_pc,
    input  upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_is_jalr
  );

  modport slave (
    input  enq_valid, enq_pc, enq_taken,
    input  enq_target, enq_is_jalr,
    input  res_valid, res_taken, res_target,
    input  flush,
    output enq_ready, mispredict, redirect_pc,
    output upd_valid, upd_pc, upd_taken,
    output upd_target, upd_is_jalr
  );

endinterface

// File: rtl/brq_entry_fifo.sv
// DEPTH-entry FIFO of brq_entry_t with push/pop/clear and occupancy.
// Ports: clk, rst, clear, push, din, pop, dout, count, full, empty.
module brq_entry_fifo
  import branch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  brq_entry_t               din,
  input  logic                     pop,
  output brq_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  brq_entry_t mem [DEPTH];
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       cnt;

  assign count = cnt;
  assign full  = (cnt == cnt_t'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      unique case (1'b1)
        push && !pop: cnt <= cnt + cnt_t'(1);
        pop && !push: cnt <= cnt - cnt_t'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-flight prediction tracker: compares resolutions, drives update bus.
// Ports: CLK, RST, bus (slave), count, err_underflow; BRQ_STATS_EN adds stats.
module branch_resolve_queue
  import branch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BRQ_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  branch_resolve_queue_if.slave  bus,
  output logic [$clog2(DEPTH):0] count,
`ifdef BRQ_STATS_EN
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispred,
`endif
  output logic                   err_underflow
);

  brq_entry_t  head;
  brq_entry_t  din;
  brq_result_t res;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        clr;

  assign bus.enq_ready = !full;

  // Flush wins over both ports; a mispredict kills the
  // younger wrong-path entries and any same-cycle enqueue.
  assign pop  = bus.res_valid && !empty && !bus.flush;
  assign clr  = bus.flush || res.mispredict;
  assign push = bus.enq_valid && !full && !clr;

  assign din.pc      = bus.enq_pc;
  assign din.taken   = bus.enq_taken;
  assign din.target  = bus.enq_target;
  assign din.is_jalr = bus.enq_is_jalr;

  always_comb begin
    res = '0;
    if (pop) begin
      res.mispredict =
        (head.taken != bus.res_taken) ||
        (bus.res_taken &&
         (head.target != bus.res_target));
      res.redirect_pc = bus.res_taken
                      ? bus.res_target
                      : next_seq_pc(head.pc);
    end
  end

  brq_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .clear (clr),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.upd_valid   <= 1'b0;
      bus.upd_pc      <= '0;
      bus.upd_taken   <= 1'b0;
      bus.upd_target  <= '0;
      bus.upd_is_jalr <= 1'b0;
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
      err_underflow   <= 1'b0;
    end else begin
      bus.upd_valid  <= pop;
      bus.mispredict <= res.mispredict;
      if (pop) begin
        bus.upd_pc      <= head.pc;
        bus.upd_taken   <= bus.res_taken;
        bus.upd_target  <= bus.res_target;
        bus.upd_is_jalr <= head.is_jalr;
        bus.redirect_pc <= res.redirect_pc;
      end
      if (bus.res_valid && empty)
        err_underflow <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  // Saturating; flush does not clear them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && (stat_resolved != '1))
        stat_resolved <= stat_resolved + 32'd1;
      if (res.mispredict && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule
